// File: rtl/gerador_pwm_rampa_pkg.sv
// Shared definitions for the ramped PWM generator: FSM encodings and
// default timing constants matching the upstream modulo-M period counter.
package gerador_pwm_rampa_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        RAMPA    = 2'b01,
        ESTAVEL  = 2'b10,
        INVALIDO = 2'b11
    } estado_t;

    localparam int M_PADRAO           = 2000;
    localparam int N_PADRAO           = 13;
    localparam int LARGURA_MIN_PADRAO = 100;
    localparam int LARGURA_MAX_PADRAO = 200;
    localparam int PASSO_PADRAO       = 5;

endpackage

// File: rtl/gerador_pwm_rampa_if.sv
// Signal bundle between the command/counter side and the PWM generator.
// master: the side that supplies phase, period end, enable and target.
// slave:  the PWM generator itself.
interface gerador_pwm_rampa_if
    import gerador_pwm_rampa_pkg::*;
    #(parameter int N = N_PADRAO);

    logic         habilita;
    logic [N-1:0] Q;
    logic         fim;
    logic [N-1:0] largura_alvo;
    logic         carrega;
    logic         pwm;
    logic [N-1:0] largura_atual;
    logic         estavel;
    logic [1:0]   db_estado;

    modport master (
        output habilita, Q, fim, largura_alvo, carrega,
        input  pwm, largura_atual, estavel, db_estado
    );

    modport slave (
        input  habilita, Q, fim, largura_alvo, carrega,
        output pwm, largura_atual, estavel, db_estado
    );

endinterface

// File: rtl/gerador_pwm_rampa_passo.sv
// Slew step: moves the applied width at most PASSO ticks toward the target,
// then keeps the result inside [LARGURA_MIN, LARGURA_MAX].
module gerador_pwm_rampa_passo #(
    parameter int N           = 13,
    parameter int LARGURA_MIN = 100,
    parameter int LARGURA_MAX = 200,
    parameter int PASSO       = 5
) (
    input  logic [N-1:0] atual,
    input  logic [N-1:0] alvo,
    output logic [N-1:0] proxima
);

    localparam logic signed [N:0] PASSO_S = (N+1)'(PASSO);
    localparam logic signed [N:0] MIN_S   = (N+1)'(LARGURA_MIN);
    localparam logic signed [N:0] MAX_S   = (N+1)'(LARGURA_MAX);

    // Differences are taken one bit wider so a target below the current
    // width yields a negative value instead of wrapping.
    function automatic logic [N-1:0] satura_faixa(input logic signed [N:0] v);
        logic signed [N:0] r;
        if (v < MIN_S)
            r = MIN_S;
        else if (v > MAX_S)
            r = MAX_S;
        else
            r = v;
        return r[N-1:0];
    endfunction

    logic signed [N:0] diferenca;
    logic signed [N:0] candidata;

    // Limited step toward the target, followed by range saturation.
    always_comb begin
        diferenca = $signed({1'b0, alvo}) - $signed({1'b0, atual});
        if (diferenca > PASSO_S)
            candidata = $signed({1'b0, atual}) + PASSO_S;
        else if (diferenca < -PASSO_S)
            candidata = $signed({1'b0, atual}) - PASSO_S;
        else
            candidata = $signed({1'b0, alvo});
        proxima = satura_faixa(candidata);
    end

endmodule

// File: rtl/gerador_pwm_rampa.sv
// Motor/ESC PWM generator with soft start: the active width slews toward the
// commanded target by at most PASSO ticks per period, and changes only at the
// period boundary (fim) so a pulse is never reshaped while it is being output.
module gerador_pwm_rampa
    import gerador_pwm_rampa_pkg::*;
#(
    parameter int M           = M_PADRAO,
    parameter int N           = N_PADRAO,
    parameter int LARGURA_MIN = LARGURA_MIN_PADRAO,
    parameter int LARGURA_MAX = LARGURA_MAX_PADRAO,
    parameter int PASSO       = PASSO_PADRAO
) (
    input logic                clock,
    input logic                reset,
    gerador_pwm_rampa_if.slave bus
);

    localparam logic [N-1:0] M_W   = N'(M);
    localparam logic [N-1:0] MIN_W = N'(LARGURA_MIN);
    localparam logic [N-1:0] MAX_W = N'(LARGURA_MAX);

    // Commanded widths outside the legal pulse range are pulled to the edge.
    function automatic logic [N-1:0] satura_alvo(input logic [N-1:0] v);
        if (v < MIN_W)
            return MIN_W;
        else if (v > MAX_W)
            return MAX_W;
        else
            return v;
    endfunction

    estado_t      estado;
    estado_t      estado_prox;
    logic [N-1:0] largura_atual;
    logic [N-1:0] atual_prox;
    logic [N-1:0] alvo;
    logic [N-1:0] largura_passo;
    logic         pwm_r;
    logic         q_valido;

    gerador_pwm_rampa_passo #(
        .N           (N),
        .LARGURA_MIN (LARGURA_MIN),
        .LARGURA_MAX (LARGURA_MAX),
        .PASSO       (PASSO)
    ) u_passo (
        .atual   (largura_atual),
        .alvo    (alvo),
        .proxima (largura_passo)
    );

    // A phase outside 0..M-1 never produces an active pulse.
    assign q_valido = (bus.Q < M_W);

    // Next state and next width; losing enable cuts everything immediately.
    always_comb begin
        estado_prox = estado;
        atual_prox  = largura_atual;
        if (!bus.habilita) begin
            estado_prox = PARADO;
            atual_prox  = '0;
        end else begin
            case (estado)
                PARADO: begin
                    atual_prox = '0;
                    if (bus.fim) begin
                        estado_prox = RAMPA;
                        atual_prox  = MIN_W;
                    end
                end
                RAMPA: begin
                    if (bus.fim) begin
                        atual_prox = largura_passo;
                        if (largura_passo == alvo)
                            estado_prox = ESTAVEL;
                    end
                end
                ESTAVEL: begin
                    if (alvo != largura_atual)
                        estado_prox = RAMPA;
                end
                default: begin
                    estado_prox = PARADO;
                    atual_prox  = '0;
                end
            endcase
        end
    end

    // State and applied width registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= PARADO;
            largura_atual <= '0;
        end else begin
            estado        <= estado_prox;
            largura_atual <= atual_prox;
        end
    end

    // Target latch; a fim in the same cycle still sees the previous target.
    always_ff @(posedge clock) begin
        if (reset)
            alvo <= MIN_W;
        else if (bus.carrega)
            alvo <= satura_alvo(bus.largura_alvo);
    end

    // Registered PWM comparator, forced low as soon as enable drops.
    always_ff @(posedge clock) begin
        if (reset)
            pwm_r <= 1'b0;
        else
            pwm_r <= bus.habilita && (estado != PARADO) && q_valido
                     && (bus.Q < largura_atual);
    end

    assign bus.pwm           = pwm_r;
    assign bus.largura_atual = largura_atual;
    assign bus.estavel       = (estado == ESTAVEL);
    assign bus.db_estado     = estado;

endmodule

// File: tb/tb_gerador_pwm_rampa.sv
// Bench for the ramped PWM generator. A short period (M_TB) keeps the
// multi-period ramps cheap; widths and step are the default values.
module tb_gerador_pwm_rampa;

    localparam int N    = 13;
    localparam int M_TB = 250;

    typedef struct {
        logic [N-1:0] largura_alvo;
        logic [N-1:0] esperado;
    } vetor_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total  = 0;
    int   falhas = 0;

    always #5 clock = ~clock;

    gerador_pwm_rampa_if #(.N(N)) bus ();

    gerador_pwm_rampa #(
        .M           (M_TB),
        .N           (N),
        .LARGURA_MIN (100),
        .LARGURA_MAX (200),
        .PASSO       (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Upstream modulo-M period counter model.
    logic [N-1:0] q_cont = '0;
    always @(posedge clock) q_cont <= (q_cont == N'(M_TB - 1)) ? '0 : q_cont + 1'b1;
    assign bus.Q   = q_cont;
    assign bus.fim = (q_cont == N'(M_TB - 1));

    task automatic verifica(input string nome, input logic [31:0] obtido,
                            input logic [31:0] esperado);
        total++;
        if (obtido !== esperado) begin
            falhas++;
            $display("FAIL %s: obtido %0d, esperado %0d", nome, obtido, esperado);
        end
    endtask

    task automatic falha_tempo(input string nome);
        total++;
        falhas++;
        $display("FAIL %s: limite de ciclos esgotado", nome);
    endtask

    // Returns at the falling edge right after the next period-end edge.
    task automatic espera_fim();
        bit ok = 1'b0;
        for (int i = 0; i < 2 * M_TB; i++) begin
            if (bus.fim === 1'b1) begin
                @(negedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) falha_tempo("espera_fim");
    endtask

    task automatic ate_fim();
        bit ok = 1'b0;
        for (int i = 0; i < 2 * M_TB; i++) begin
            if (bus.fim === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) falha_tempo("ate_fim");
    endtask

    task automatic espera_estavel();
        bit ok = 1'b0;
        for (int i = 0; i < 30 * M_TB; i++) begin
            if (bus.estavel === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) falha_tempo("espera_estavel");
    endtask

    task automatic pulsa_carrega(input logic [N-1:0] v);
        bus.largura_alvo = v;
        bus.carrega      = 1'b1;
        @(negedge clock);
        bus.carrega      = 1'b0;
    endtask

    // Counts high pwm cycles over one whole period following a fim.
    task automatic mede_largura(output int n);
        n = 0;
        espera_fim();
        for (int i = 0; i < M_TB; i++) begin
            @(negedge clock);
            if (bus.pwm === 1'b1) n++;
        end
    endtask

    vetor_t tabela [7];
    int     largura;
    int     n_pwm, n_atual, n_estado;
    bit     achou;

    initial begin
        tabela[0] = '{13'd1500, 13'd200};
        tabela[1] = '{13'd150,  13'd150};
        tabela[2] = '{13'd99,   13'd100};
        tabela[3] = '{13'd50,   13'd100};
        tabela[4] = '{13'd200,  13'd200};
        tabela[5] = '{13'd201,  13'd200};
        tabela[6] = '{13'd160,  13'd160};

        bus.habilita     = 1'b0;
        bus.carrega      = 1'b0;
        bus.largura_alvo = '0;
        reset            = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state.
        verifica("reset_pwm",     32'(bus.pwm), 0);
        verifica("reset_atual",   32'(bus.largura_atual), 0);
        verifica("reset_estado",  32'(bus.db_estado), 0);
        verifica("reset_estavel", 32'(bus.estavel), 0);

        // Disabled output over three periods.
        reset    = 1'b0;
        n_pwm    = 0;
        n_atual  = 0;
        n_estado = 0;
        for (int i = 0; i < 3 * M_TB; i++) begin
            @(negedge clock);
            if (bus.pwm !== 1'b0) n_pwm++;
            if (bus.largura_atual !== '0) n_atual++;
            if (bus.db_estado !== 2'b00) n_estado++;
        end
        verifica("parado_pwm",    n_pwm, 0);
        verifica("parado_atual",  n_atual, 0);
        verifica("parado_estado", n_estado, 0);

        // Soft start up to 200.
        pulsa_carrega(13'd200);
        bus.habilita = 1'b1;
        espera_fim();
        verifica("arranque_atual",  32'(bus.largura_atual), 100);
        verifica("arranque_estado", 32'(bus.db_estado), 1);
        for (int k = 1; k <= 20; k++) begin
            espera_fim();
            verifica("subida_atual", 32'(bus.largura_atual), 32'(100 + 5 * k));
        end
        verifica("subida_estavel", 32'(bus.estavel), 1);
        verifica("subida_estado",  32'(bus.db_estado), 2);
        mede_largura(largura);
        verifica("largura_200", largura, 200);

        // Ramp down from 200 to 102.
        pulsa_carrega(13'd102);
        @(negedge clock);
        verifica("descida_sai_estavel", 32'(bus.estavel), 0);
        verifica("descida_estado",      32'(bus.db_estado), 1);
        for (int k = 1; k <= 19; k++) begin
            espera_fim();
            verifica("descida_atual", 32'(bus.largura_atual), 32'(200 - 5 * k));
        end
        espera_fim();
        verifica("descida_final",   32'(bus.largura_atual), 102);
        verifica("descida_estavel", 32'(bus.estavel), 1);

        // Target below minimum settles at 100 with estavel.
        pulsa_carrega(13'd50);
        espera_fim();
        verifica("clamp50_atual",   32'(bus.largura_atual), 100);
        verifica("clamp50_estavel", 32'(bus.estavel), 1);

        // carrega coinciding with fim: that fim uses the old target.
        pulsa_carrega(13'd110);
        ate_fim();
        bus.largura_alvo = 13'd150;
        bus.carrega      = 1'b1;
        espera_fim();
        bus.carrega      = 1'b0;
        verifica("colisao_alvo_antigo", 32'(bus.largura_atual), 105);
        espera_fim();
        verifica("colisao_alvo_novo",   32'(bus.largura_atual), 110);

        // Clamp and steady-width table.
        for (int v = 0; v < 7; v++) begin
            pulsa_carrega(tabela[v].largura_alvo);
            @(negedge clock);
            espera_estavel();
            verifica("tabela_atual", 32'(bus.largura_atual), 32'(tabela[v].esperado));
            mede_largura(largura);
            verifica("tabela_largura", largura, 32'(tabela[v].esperado));
        end

        // Emergency cut mid-pulse at Q=50.
        achou = 1'b0;
        for (int i = 0; i < 2 * M_TB; i++) begin
            if (bus.Q == 13'd50) begin
                achou = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!achou) falha_tempo("espera_q50");
        verifica("corte_pwm_antes", 32'(bus.pwm), 1);
        bus.habilita = 1'b0;
        @(negedge clock);
        verifica("corte_pwm",    32'(bus.pwm), 0);
        verifica("corte_atual",  32'(bus.largura_atual), 0);
        verifica("corte_estado", 32'(bus.db_estado), 0);

        // Re-enable restarts from the minimum width.
        bus.habilita = 1'b1;
        espera_fim();
        verifica("rearme_atual",  32'(bus.largura_atual), 100);
        verifica("rearme_estado", 32'(bus.db_estado), 1);
        espera_fim();
        verifica("rearme_rampa",  32'(bus.largura_atual), 105);

        // Reset mid-ramp.
        reset = 1'b1;
        @(negedge clock);
        verifica("reset_meio_pwm",     32'(bus.pwm), 0);
        verifica("reset_meio_atual",   32'(bus.largura_atual), 0);
        verifica("reset_meio_estado",  32'(bus.db_estado), 0);
        verifica("reset_meio_estavel", 32'(bus.estavel), 0);
        reset = 1'b0;
        espera_fim();
        verifica("pos_reset_atual", 32'(bus.largura_atual), 100);
        espera_fim();
        verifica("pos_reset_alvo_min", 32'(bus.largura_atual), 100);
        verifica("pos_reset_estavel",  32'(bus.estavel), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", total, falhas);
        $finish;
    end

endmodule
